// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: widths, reset/flush constants and fetch FSM encoding.
package cpu_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0000;

   // Fetch FSM encoding, kept as plain constants for legacy tools.
   localparam logic [1:0] ST_REQ  = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
   } if_entry_t;

   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_skid_reg.sv
// One-entry holding register for an instruction that returns while decode is stalled.
module if_skid_reg
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] FLUSH_INST = NOP_INST
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      load,
   input  logic      clear,
   input  logic      drain,
   input  if_entry_t data,
   output if_entry_t entry,
   output logic      full
);

   // NOTE: reset is synchronous and active-low, so it lives inside the clocked block.
   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         entry <= '{inst: FLUSH_INST, pc: '0};
         full  <= 1'b0;
      end else if (drain) begin
         full  <= 1'b0;
      end else if (load) begin
         entry <= data;
         full  <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, keeps one memory request in flight and fills IF/ID.
module fetch
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter logic [XLEN-1:0] FLUSH_INST = NOP_INST
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stop,
   input  logic            jump,
   input  logic [XLEN-1:0] jump_target,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            imem_valid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] inst_IFID,
   output logic [XLEN-1:0] pc_out,
   output logic            valid_IFID,
   output logic            fetch_busy
);

   logic [1:0]      state, state_nxt;
   logic [XLEN-1:0] pc, pc_nxt;
   if_entry_t       ifid, ifid_nxt;
   logic            ifid_valid, ifid_valid_nxt;

   logic            handshake;
   logic            deliver;
   if_entry_t       deliver_entry;
   if_entry_t       capture;

   logic            skid_load, skid_clear, skid_drain;
   if_entry_t       skid_entry;
   logic            skid_full;

   assign imem_req   = rst && (state == ST_REQ);
   assign imem_addr  = pc;
   assign handshake  = imem_req && imem_ready;
   assign capture    = '{inst: imem_rdata, pc: pc};

   assign inst_IFID  = ifid.inst;
   assign pc_out     = ifid.pc;
   assign valid_IFID = ifid_valid;
   assign fetch_busy = (state == ST_WAIT) || (state == ST_DROP);

   if_skid_reg #(
      .FLUSH_INST (FLUSH_INST)
   ) u_skid (
      .clk   (clk),
      .rst   (rst),
      .load  (skid_load),
      .clear (skid_clear),
      .drain (skid_drain),
      .data  (capture),
      .entry (skid_entry),
      .full  (skid_full)
   );

   // NOTE: every signal gets a default at the top so no path leaves one unassigned (no latches).
   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc;
      ifid_nxt       = ifid;
      ifid_valid_nxt = ifid_valid;
      skid_load      = 1'b0;
      skid_clear     = 1'b0;
      skid_drain     = 1'b0;
      deliver        = 1'b0;
      deliver_entry  = capture;

      if (jump) begin
         pc_nxt         = align_pc(jump_target);
         ifid_nxt.inst  = FLUSH_INST;
         ifid_valid_nxt = 1'b0;
         skid_clear     = 1'b0 | 1'b1;
         // A request still in flight must be drained before the redirected fetch starts.
         case (state)
            ST_WAIT: state_nxt = imem_valid ? ST_REQ : ST_DROP;
            ST_REQ:  state_nxt = handshake  ? ST_DROP : ST_REQ;
            ST_DROP: state_nxt = imem_valid ? ST_REQ : ST_DROP;
            default: state_nxt = ST_REQ;
         endcase
      end else begin
         case (state)
            ST_REQ: begin
               if (handshake) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
               if (imem_valid) begin
                  pc_nxt = pc + 32'd4;
                  if (stop) begin
                     skid_load = 1'b1;
                     state_nxt = ST_HOLD;
                  end else begin
                     deliver   = 1'b1;
                     state_nxt = ST_REQ;
                  end
               end
            end
            ST_HOLD: begin
               if (!stop) begin
                  deliver       = skid_full;
                  deliver_entry = skid_entry;
                  skid_drain    = 1'b1;
                  state_nxt     = ST_REQ;
               end
            end
            default: begin
               if (imem_valid) state_nxt = ST_REQ;
            end
         endcase

         // A stalled decode keeps IF/ID as is; otherwise it gets new work or a bubble.
         if (!stop) begin
            if (deliver) begin
               ifid_nxt       = deliver_entry;
               ifid_valid_nxt = 1'b1;
            end else begin
               ifid_nxt.inst  = FLUSH_INST;
               ifid_valid_nxt = 1'b0;
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_REQ;
         pc         <= RESET_PC;
         ifid       <= '{inst: FLUSH_INST, pc: '0};
         ifid_valid <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         ifid       <= ifid_nxt;
         ifid_valid <= ifid_valid_nxt;
      end
   end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed scenarios plus random stall/redirect/latency traffic against an
// instruction-stream model (decode must see contiguous PCs, restarting at each redirect target).
module tb_fetch;

   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] FLUSH_INST = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst, stop, jump;
   logic [31:0] jump_target;
   logic        imem_req, imem_ready, imem_valid;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] inst_IFID, pc_out;
   logic        valid_IFID, fetch_busy;

   int checks_total  = 0;
   int checks_passed = 0;
   int checks_failed = 0;

   // memory responder state
   logic        mem_busy = 1'b0;
   int          mem_cnt  = 0;
   int          mem_lat  = 1;
   logic [31:0] mem_addr = '0;

   // stream model state
   logic [31:0] exp_pc = RESET_PC;
   int          consumed = 0;
   logic        hold_pending = 1'b0;
   logic [31:0] held_addr = '0;

   fetch #(
      .RESET_PC   (RESET_PC),
      .FLUSH_INST (FLUSH_INST)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stop        (stop),
      .jump        (jump),
      .jump_target (jump_target),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_valid  (imem_valid),
      .imem_rdata  (imem_rdata),
      .inst_IFID   (inst_IFID),
      .pc_out      (pc_out),
      .valid_IFID  (valid_IFID),
      .fetch_busy  (fetch_busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      return (a * 32'h9E37_79B1) ^ 32'h1357_0013;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_total++;
      assert (got === exp) checks_passed++;
      else begin
         checks_failed++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: called at a falling edge, drives inputs for the next rising edge,
   // updates the memory and stream models, and returns at the following falling edge.
   task automatic step(input logic s, input logic j, input logic [31:0] t, input logic rdy);
      imem_valid = 1'b0;
      imem_rdata = $urandom;
      if (mem_busy) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            imem_valid = 1'b1;
            imem_rdata = mem_word(mem_addr);
            mem_busy   = 1'b0;
         end
      end
      stop        = s;
      jump        = j;
      jump_target = t;
      imem_ready  = rdy && !mem_busy;
      #1;
      if (rst && hold_pending) begin
         check("req_held", {31'd0, imem_req}, 32'd1);
         check("addr_held", imem_addr, held_addr);
      end
      hold_pending = rst && imem_req && !imem_ready && !j;
      held_addr    = imem_addr;
      if (rst && imem_req && imem_ready) begin
         mem_busy = 1'b1;
         mem_cnt  = mem_lat;
         mem_addr = imem_addr;
      end
      if (!rst) begin
         exp_pc = RESET_PC;
      end else if (j) begin
         exp_pc = {t[31:2], 2'b00};
      end else if (!s && valid_IFID) begin
         check("stream_pc", pc_out, exp_pc);
         check("stream_inst", inst_IFID, mem_word(exp_pc));
         exp_pc = exp_pc + 32'd4;
         consumed++;
      end else if (!valid_IFID) begin
         check("bubble_inst", inst_IFID, FLUSH_INST);
      end
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] tgt;
      int          live_ok;

      rst = 1'b0; stop = 1'b0; jump = 1'b0; jump_target = '0;
      imem_ready = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
      @(negedge clk);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      check("rst_valid", {31'd0, valid_IFID}, 32'd0);
      check("rst_inst", inst_IFID, FLUSH_INST);
      check("rst_pc_out", pc_out, 32'd0);
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_busy", {31'd0, fetch_busy}, 32'd0);

      // first fetch with a 1-cycle memory
      rst = 1'b1;
      #1;
      check("first_req", {31'd0, imem_req}, 32'd1);
      check("first_addr", imem_addr, RESET_PC);
      step(0, 0, 0, 1);
      check("wait_busy", {31'd0, fetch_busy}, 32'd1);
      step(0, 0, 0, 1);
      check("first_inst", inst_IFID, 32'h0050_0093);
      check("first_pc", pc_out, 32'd0);
      check("first_valid", {31'd0, valid_IFID}, 32'd1);
      check("next_addr", imem_addr, 32'd4);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);

      // memory refuses three cycles at pc 8
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0);
         check("nordy_req", {31'd0, imem_req}, 32'd1);
         check("nordy_addr", imem_addr, 32'd8);
         check("nordy_valid", {31'd0, valid_IFID}, 32'd0);
         check("nordy_inst", inst_IFID, FLUSH_INST);
      end
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);

      // response for pc 12 lands under stall
      for (int i = 0; i < 2; i++) begin
         step(1, 0, 0, 1);
         check("stall_valid", {31'd0, valid_IFID}, 32'd0);
         check("stall_inst", inst_IFID, FLUSH_INST);
         check("stall_req", {31'd0, imem_req}, 32'd0);
      end
      step(0, 0, 0, 1);
      check("skid_inst", inst_IFID, mem_word(32'd12));
      check("skid_pc", pc_out, 32'd12);
      check("skid_valid", {31'd0, valid_IFID}, 32'd1);
      check("skid_next_addr", imem_addr, 32'd16);

      // redirect while a 4-cycle fetch is outstanding
      mem_lat = 4;
      step(0, 0, 0, 1);
      step(0, 1, 32'h0000_0103, 1);
      check("drop_valid", {31'd0, valid_IFID}, 32'd0);
      check("drop_req", {31'd0, imem_req}, 32'd0);
      check("drop_busy", {31'd0, fetch_busy}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 1);
         check("drop_no_inst", {31'd0, valid_IFID}, 32'd0);
      end
      check("redir_req", {31'd0, imem_req}, 32'd1);
      check("redir_addr", imem_addr, 32'h0000_0100);
      for (int i = 0; i < 12 && !valid_IFID; i++) step(0, 0, 0, 1);
      check("redir_valid", {31'd0, valid_IFID}, 32'd1);
      check("redir_inst", inst_IFID, mem_word(32'h100));
      check("redir_pc", pc_out, 32'h100);

      // jump, stop and response in the same cycle
      mem_lat = 1;
      step(0, 0, 0, 1);
      step(1, 1, 32'h0000_0200, 1);
      check("jsv_inst", inst_IFID, FLUSH_INST);
      check("jsv_valid", {31'd0, valid_IFID}, 32'd0);
      check("jsv_req", {31'd0, imem_req}, 32'd1);
      check("jsv_addr", imem_addr, 32'h0000_0200);
      check("jsv_busy", {31'd0, fetch_busy}, 32'd0);

      // reset in the middle of a 3-cycle fetch, stale response afterwards
      mem_lat = 3;
      step(0, 0, 0, 1);
      rst = 1'b0;
      step(0, 0, 0, 1);
      check("mrst_valid", {31'd0, valid_IFID}, 32'd0);
      check("mrst_inst", inst_IFID, FLUSH_INST);
      check("mrst_pc_out", pc_out, 32'd0);
      check("mrst_busy", {31'd0, fetch_busy}, 32'd0);
      rst = 1'b1;
      #1;
      check("mrst_req", {31'd0, imem_req}, 32'd1);
      check("mrst_addr", imem_addr, RESET_PC);
      mem_lat = 1;
      step(0, 0, 0, 1);
      check("stale_wait", {31'd0, valid_IFID}, 32'd0);
      step(0, 0, 0, 1);
      check("stale_ignored", {31'd0, valid_IFID}, 32'd0);
      step(0, 0, 0, 1);
      check("mrst_inst0", inst_IFID, 32'h0050_0093);
      check("mrst_pc0", pc_out, RESET_PC);
      check("mrst_valid0", {31'd0, valid_IFID}, 32'd1);

      // PC wrap at the top of the address space
      step(0, 1, 32'hFFFF_FFFE, 0);
      check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      check("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
      check("wrap_inst", inst_IFID, mem_word(32'hFFFF_FFFC));
      check("wrap_next", imem_addr, 32'd0);

      // random traffic against the stream model
      consumed = 0;
      for (int i = 0; i < 3000; i++) begin
         rst     = ($urandom_range(0, 199) != 0);
         mem_lat = $urandom_range(1, 4);
         tgt     = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                               : ($urandom & 32'h0000_FFFF);
         step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, tgt,
              $urandom_range(0, 9) < 7);
      end
      live_ok = (consumed > 50) ? 1 : 0;
      check("liveness", live_ok, 32'd1);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction-fetch stage: owns the PC and issues one instruction-memory request at a time.
- Accepts the variable-latency response and drives the IF/ID pipeline register (inst_IFID, pc_out) consumed by decode.
- Honours the downstream stall (stop) and redirects on a resolved branch/jump (jump, jump_target).
- Killed in-flight fetches are discarded, never forwarded.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FLUSH_INST, 32'h0000_0000, instruction word driven when IF/ID holds no valid instruction (decode treats it as no-op).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- stop  in  1  downstream stall: hold IF/ID.
- jump  in  1  redirect/flush request from EX.
- jump_target  in  32  redirect PC; bits [1:0] ignored, forced 0.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address (current PC).
- imem_ready  in  1  memory accepts request this cycle.
- imem_valid  in  1  response data valid.
- imem_rdata  in  32  response instruction word.
- inst_IFID  out  32  instruction to decode.
- pc_out  out  32  PC of inst_IFID.
- valid_IFID  out  1  inst_IFID is a real instruction.
- fetch_busy  out  1  request outstanding (state WAIT or DROP).

Behaviour:
- Reset (rst=0 at posedge):
  - pc=RESET_PC, state=REQ, inst_IFID=FLUSH_INST, pc_out=0, valid_IFID=0, skid empty.
  - imem_req is forced 0 while rst=0.
  - A late imem_valid after reset release is ignored, because state is not WAIT.
- One outstanding request max. States: REQ, WAIT, DROP, HOLD.
- REQ:
  - imem_req=1, imem_addr=pc.
  - imem_req && imem_ready → WAIT. Otherwise stay in REQ.
- WAIT:
  - imem_valid=0: stay.
  - imem_valid=1, stop=0: IF/ID ← {imem_rdata, pc}, valid_IFID=1, pc ← pc+4 → REQ.
  - imem_valid=1, stop=1: skid ← {imem_rdata, pc}, pc ← pc+4 → HOLD.
- HOLD:
  - imem_req=0.
  - While stop=1, IF/ID and skid unchanged.
  - On stop=0: IF/ID ← skid, valid_IFID=1, skid cleared → REQ.
- DROP:
  - Wait for imem_valid of the killed request; discard its data → REQ.
  - imem_req=0.
- No new instruction and stop=0: IF/ID ← {FLUSH_INST, pc_out unchanged}, valid_IFID=0.
- stop=1 (no jump): IF/ID holds all fields.
- jump=1 has priority over stop and all state actions:
  - pc ← {jump_target[31:2], 2'b00}.
  - IF/ID ← FLUSH_INST, valid_IFID=0. Skid cleared.
  - Next state:
    - WAIT without imem_valid this cycle → DROP.
    - WAIT with imem_valid this cycle → REQ; data discarded.
    - REQ with handshake this cycle → DROP.
    - REQ without handshake, HOLD, or DROP → REQ if nothing is outstanding, else DROP.
- Latency: minimum 2 cycles from request acceptance to valid_IFID (1-cycle memory).
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- imem_addr is stable while imem_req=1 and imem_ready=0.

Decomposition:
- Shared package `cpu_pkg`: RESET_PC default, FLUSH_INST/NOP constant, fetch state encoding (REQ, WAIT, DROP, HOLD), instruction width 32.
- One sub-module, `if_skid_reg`: 1-entry {inst, pc, valid} holding register with load/clear/drain controls.
- The FSM and PC register stay in fetch.

Test Plan:
- Reset then 1-cycle memory, imem_rdata=32'h00500093 at 0:
  - First request has imem_addr=0.
  - inst_IFID=32'h00500093, pc_out=0, valid_IFID=1.
  - Next imem_addr=4.
- imem_ready low 3 cycles at pc=8:
  - imem_req held 1, imem_addr held 8.
  - valid_IFID=0, inst_IFID=FLUSH_INST meanwhile.
- stop=1 when response for pc=12 arrives:
  - IF/ID unchanged, imem_req=0.
  - Two cycles later stop=0: inst_IFID=word@12, pc_out=12, then imem_addr=16.
- jump=1, jump_target=32'h0000_0103, during WAIT with a 4-cycle memory:
  - Late response dropped, never reaches IF/ID.
  - Next imem_addr=32'h0000_0100; valid_IFID=0 until the @0x100 word arrives.
- Simultaneous jump=1, stop=1, imem_valid=1:
  - Data discarded, IF/ID=FLUSH_INST, valid_IFID=0.
  - Next imem_addr=jump_target.
- rst=0 asserted mid-WAIT:
  - Outputs return to reset values.
  - Stale imem_valid afterwards is ignored.
  - First post-reset imem_addr=RESET_PC.
  - Wrap check: pc=32'hFFFF_FFFC fetch gives next imem_addr=0.
